tetris_board_writer: RTL and testbench



---
 rtl/tetris_board_writer_pkg.sv | 35 +++
 rtl/tetris_board_writer_if.sv | 37 +++
 rtl/tetris_board_writer_row_shift.sv | 26 ++
 rtl/tetris_board_writer.sv | 136 +++++++++++++
 tb/tb_tetris_board_writer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_board_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_pkg
// Description : Shared playfield dimensions, board type, engine state type
//               and a saturating line-counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;

    // Board image, [row][col], row 0 is the top of the well.
    typedef logic [BOARD_ROWS-1:0][BOARD_COLS-1:0] board_t;

    // Row-scan engine states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [4:0] c_LAST_ROW  = 5'(BOARD_ROWS - 1);
    localparam logic [9:0] c_TOTAL_MAX = 10'd1023;

    // Adds a per-lock line count to the running total, clamping at 1023.
    function automatic logic [9:0] sat_add_lines(input logic [9:0] i_total,
                                                 input logic [2:0] i_cnt);
        logic [10:0] w_sum;
        w_sum = {1'b0, i_total} + {8'd0, i_cnt};
        return w_sum[10] ? c_TOTAL_MAX : w_sum[9:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/tetris_board_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : tetris_board_writer_if
// Description : Lock handshake, masks and result signals between the
//               game-control FSM (master) and the board writer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface tetris_board_writer_if
    import tetris_pkg::*;
    ();

    logic        clear_grid;
    logic        lock_valid;
    logic        lock_ready;
    board_t      lock_mask;
    board_t      active_mask;
    board_t      display_array;
    logic        collision;
    logic        clear_done;
    logic [2:0]  lines_cleared;
    logic [9:0]  total_lines;
    logic        gameover;

    modport master (
        output clear_grid, lock_valid, lock_mask, active_mask,
        input  lock_ready, display_array, collision, clear_done,
               lines_cleared, total_lines, gameover
    );

    modport slave (
        input  clear_grid, lock_valid, lock_mask, active_mask,
        output lock_ready, display_array, collision, clear_done,
               lines_cleared, total_lines, gameover
    );

endinterface
`default_nettype wire

// File: rtl/tetris_board_writer_row_shift.sv
`default_nettype none
// ============================================================================
// Module      : board_row_shift
// Description : Combinational row collapse. Rows i_row..1 take rows
//               i_row-1..0, rows below i_row are untouched, row 0 is zeroed.
// Revision    : 1.0 - initial release
// ============================================================================
module board_row_shift
    import tetris_pkg::*;
(
    input  board_t     i_board,
    input  logic [4:0] i_row,
    output board_t     o_board
);

    for (genvar g = 0; g < BOARD_ROWS; g++) begin : g_row
        if (g == 0) begin : g_top
            // The top row always refills with empty cells.
            assign o_board[g] = '0;
        end else begin : g_body
            assign o_board[g] = (i_row >= 5'(g)) ? i_board[g-1] : i_board[g];
        end
    end

endmodule
`default_nettype wire

// File: rtl/tetris_board_writer.sv
`default_nettype none
// ============================================================================
// Module      : tetris_board_writer
// Description : Owns the stored playfield. Merges locked pieces, collapses
//               full rows with a bottom-up row-scan engine, and publishes a
//               registered display image (board OR falling-piece overlay).
// Revision    : 1.0 - initial release
// ============================================================================
module tetris_board_writer
    import tetris_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    tetris_board_writer_if.slave   bus
);

    state_t      r_state;
    state_t      w_next_state;
    board_t      r_stored;
    board_t      r_display;
    board_t      w_shifted;
    logic [4:0]  r_row;
    logic [2:0]  r_cnt;
    logic [2:0]  r_lines;
    logic [9:0]  r_total;
    logic        r_gameover;
    logic        w_lock_ready;
    logic        w_clear_done;
    logic        w_accept;
    logic        w_row_full;
    logic        w_scan_end;

    assign w_accept   = bus.lock_valid && w_lock_ready;
    assign w_row_full = &r_stored[r_row];
    // The scan finishes on the first non-full row 0; a full row 0 is shifted
    // (becoming empty) and re-examined on the next cycle.
    assign w_scan_end = !w_row_full && (r_row == 5'd0);

    board_row_shift u_row_shift (
        .i_board (r_stored),
        .i_row   (r_row),
        .o_board (w_shifted)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; clear_grid aborts any sequence back to idle.
    always_comb begin
        w_next_state = r_state;
        if (bus.clear_grid) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept)   w_next_state = ST_SCAN;
                ST_SCAN: if (w_scan_end) w_next_state = ST_DONE;
                ST_DONE: w_next_state = ST_IDLE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Handshake and completion outputs decoded from the state.
    always_comb begin
        w_lock_ready = (r_state == ST_IDLE) && !r_gameover && !bus.clear_grid;
        w_clear_done = (r_state == ST_DONE);
    end

    // Board, row engine and result registers; the result is loaded on the
    // way into DONE so it is already valid while clear_done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stored   <= '0;
            r_row      <= '0;
            r_cnt      <= '0;
            r_lines    <= '0;
            r_total    <= '0;
            r_gameover <= 1'b0;
        end else if (bus.clear_grid) begin
            r_stored   <= '0;
            r_lines    <= '0;
            r_total    <= '0;
            r_gameover <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_stored <= r_stored | bus.lock_mask;
                        if (|(r_stored & bus.lock_mask)) begin
                            r_gameover <= 1'b1;
                        end
                        r_row <= c_LAST_ROW;
                        r_cnt <= 3'd0;
                    end
                end
                ST_SCAN: begin
                    if (w_row_full) begin
                        r_stored <= w_shifted;
                        r_cnt    <= r_cnt + 3'd1;
                    end else if (r_row == 5'd0) begin
                        r_lines <= r_cnt;
                        r_total <= sat_add_lines(r_total, r_cnt);
                    end else begin
                        r_row <= r_row - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Display image: overlay only while idle, registered every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_display <= '0;
        end else begin
            r_display <= r_stored | ((r_state == ST_IDLE) ? bus.active_mask : '0);
        end
    end

    assign bus.lock_ready    = w_lock_ready;
    assign bus.clear_done    = w_clear_done;
    assign bus.display_array = r_display;
    assign bus.collision     = |(bus.active_mask & r_stored);
    assign bus.lines_cleared = r_lines;
    assign bus.total_lines   = r_total;
    assign bus.gameover      = r_gameover;

endmodule
`default_nettype wire

// File: tb/tb_tetris_board_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tetris_board_writer
// Description : Self-checking bench: behavioural board model (compaction of
//               full rows, sequence length 21+k) compared every cycle, plus
//               directed scenarios with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tetris_board_writer;
    import tetris_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tetris_board_writer_if bus ();

    tetris_board_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drops full rows and stacks the remaining rows at the bottom.
    function automatic board_t compact(input board_t b, output int k);
        board_t o;
        int     w;
        o = '0;
        w = BOARD_ROWS - 1;
        k = 0;
        for (int i = BOARD_ROWS - 1; i >= 0; i--) begin
            if (&b[i]) begin
                k++;
            end else begin
                o[w] = b[i];
                w--;
            end
        end
        return o;
    endfunction

    // ---------------- behavioural model ----------------
    board_t     m_board = '0;
    board_t     m_disp  = '0;
    logic       m_disp_known = 1'b0;
    logic       m_live = 1'b0;
    logic       m_go = 1'b0;
    logic [9:0] m_total = '0;
    logic [2:0] m_lines = '0;
    int         m_left = 0;   // cycles until idle again; 1 means the done cycle
    int         m_k = 0;

    always @(posedge clk) begin
        int     kk;
        int     t;
        board_t nb;
        if (rst) begin
            m_board = '0; m_disp = '0; m_disp_known = 1'b1; m_live = 1'b1;
            m_go = 1'b0; m_total = '0; m_lines = '0; m_left = 0; m_k = 0;
        end else begin
            // Board contents are final in the last two cycles of a sequence.
            if (m_left == 0) begin
                m_disp = m_board | bus.active_mask; m_disp_known = 1'b1;
            end else if (m_left <= 2) begin
                m_disp = m_board; m_disp_known = 1'b1;
            end else begin
                m_disp_known = 1'b0;
            end
            if (bus.clear_grid) begin
                m_board = '0; m_go = 1'b0; m_total = '0; m_lines = '0; m_left = 0;
            end else if (m_left == 0) begin
                if (bus.lock_valid && !m_go) begin
                    if (|(m_board & bus.lock_mask)) m_go = 1'b1;
                    nb = compact(m_board | bus.lock_mask, kk);
                    m_board = nb; m_k = kk; m_left = 21 + kk;
                end
            end else begin
                m_left--;
                if (m_left == 1) begin
                    m_lines = 3'(m_k);
                    t = int'(m_total) + m_k;
                    m_total = (t > 1023) ? 10'd1023 : 10'(t);
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("lock_ready", bus.lock_ready, (m_left == 0) && !m_go && !bus.clear_grid);
            chk("clear_done", bus.clear_done, m_left == 1);
            chk("lines_cleared", bus.lines_cleared, m_lines);
            chk("total_lines", bus.total_lines, m_total);
            chk("gameover", bus.gameover, m_go);
            if (m_left <= 2) chk("collision", bus.collision, |(bus.active_mask & m_board));
            if (m_disp_known) chk("display_array", bus.display_array, m_disp);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        bus.clear_grid = 1'b1;
        tick();
        bus.clear_grid = 1'b0;
    endtask

    // Called at posedge+1 of an idle cycle; returns the cycle of clear_done
    // (0 if it never came) and leaves the bench at posedge+1 of the next cycle.
    task automatic lock_and_wait(input board_t m, output int done_cyc);
        bus.lock_valid = 1'b1;
        bus.lock_mask  = m;
        tick();
        bus.lock_valid = 1'b0;
        bus.lock_mask  = '0;
        done_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.clear_done) begin
                done_cyc = c;
                break;
            end
        end
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        board_t m;
        board_t e;
        int     d;
        logic   seen;

        bus.clear_grid = 1'b0; bus.lock_valid = 1'b0;
        bus.lock_mask = '0;    bus.active_mask = '0;

        // Reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_display", bus.display_array, '0);
        chk("rst_ready", bus.lock_ready, 1'b1);
        chk("rst_total", bus.total_lines, 10'd0);
        chk("rst_done", bus.clear_done, 1'b0);
        tick();

        // Single cell [19][0]
        m = '0; m[19][0] = 1'b1;
        lock_and_wait(m, d);
        chk("single_done_cycle", d, 21);
        @(negedge clk);
        chk("single_ready_back", bus.lock_ready, 1'b1);
        chk("single_disp_19_0", bus.display_array[19][0], 1'b1);
        tick();
        pulse_clear();

        // One full row
        m = '0; m[19] = 10'h1FF; m[18] = 10'b0000001000;
        lock_and_wait(m, d);
        m = '0; m[19][9] = 1'b1;
        lock_and_wait(m, d);
        chk("one_row_done_cycle", d, 22);
        @(negedge clk);
        chk("one_row_lines", bus.lines_cleared, 3'd1);
        chk("one_row_total", bus.total_lines, 10'd1);
        chk("one_row_disp19", bus.display_array[19], 10'b0000001000);
        chk("one_row_disp18", bus.display_array[18], 10'd0);
        tick();
        pulse_clear();

        // Four full rows
        m = '0; m[16] = 10'h1FF; m[17] = 10'h1FF; m[18] = 10'h1FF; m[19] = 10'h1FF;
        m[15] = 10'h155;
        lock_and_wait(m, d);
        m = '0; m[16][9] = 1'b1; m[17][9] = 1'b1; m[18][9] = 1'b1; m[19][9] = 1'b1;
        lock_and_wait(m, d);
        chk("four_row_done_cycle", d, 25);
        @(negedge clk);
        e = '0; e[19] = 10'h155;
        chk("four_row_board", bus.display_array, e);
        chk("four_row_lines", bus.lines_cleared, 3'd4);
        chk("four_row_total", bus.total_lines, 10'd4);
        tick();

        // Overlapping lock -> gameover
        m = '0; m[19][0] = 1'b1;
        lock_and_wait(m, d);
        chk("overlap_done_cycle", d, 21);
        @(negedge clk);
        chk("overlap_gameover", bus.gameover, 1'b1);
        chk("overlap_ready_low", bus.lock_ready, 1'b0);
        tick();
        bus.lock_valid = 1'b1; m = '0; m[0] = 10'h3FF; bus.lock_mask = m;
        repeat (3) tick();
        bus.lock_valid = 1'b0; bus.lock_mask = '0;
        pulse_clear();
        @(negedge clk);
        chk("clr_ready", bus.lock_ready, 1'b1);
        chk("clr_gameover", bus.gameover, 1'b0);
        chk("clr_total", bus.total_lines, 10'd0);
        tick();
        @(negedge clk);
        chk("clr_display", bus.display_array, '0);
        tick();

        // Full row at row 0
        m = '0; m[0] = 10'h3FF;
        lock_and_wait(m, d);
        chk("row0_done_cycle", d, 22);
        @(negedge clk);
        chk("row0_display", bus.display_array, '0);
        chk("row0_lines", bus.lines_cleared, 3'd1);
        tick();

        // clear_grid in SCAN cycle 5 together with lock_valid
        m = '0; m[0] = 10'h3FF; m[19][4] = 1'b1;
        bus.lock_valid = 1'b1; bus.lock_mask = m;
        tick();
        bus.lock_valid = 1'b0; bus.lock_mask = '0;
        repeat (4) tick();
        bus.clear_grid = 1'b1; bus.lock_valid = 1'b1;
        m = '0; m[19][1] = 1'b1; bus.lock_mask = m;
        tick();
        bus.clear_grid = 1'b0; bus.lock_valid = 1'b0; bus.lock_mask = '0;
        @(negedge clk);
        chk("abort_idle_ready", bus.lock_ready, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.clear_done) seen = 1'b1;
        end
        chk("abort_no_done", seen, 1'b0);
        chk("abort_display", bus.display_array, '0);
        tick();

        // Non-adjacent full rows 17 and 19, with overlay and collision
        m = '0; m[17] = 10'h1FF; m[19] = 10'h1FF; m[18] = 10'h001;
        lock_and_wait(m, d);
        m = '0; m[18][0] = 1'b1; bus.active_mask = m;
        @(negedge clk);
        chk("collision_hit", bus.collision, 1'b1);
        tick();
        m = '0; m[17][9] = 1'b1; m[19][9] = 1'b1;
        lock_and_wait(m, d);
        chk("gap_done_cycle", d, 23);
        tick();
        @(negedge clk);
        chk("gap_lines", bus.lines_cleared, 3'd2);
        chk("gap_disp19", bus.display_array[19], 10'h001);
        chk("gap_disp18_overlay", bus.display_array[18], 10'h001);
        chk("gap_collision_clear", bus.collision, 1'b0);
        tick();
        bus.active_mask = '0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
